// File: rtl/ram_1wnr_clr_pkg.sv
// Shared types and sizing helpers for the 1-write / N-read partial-sum RAM.
// Holds the clear-FSM state type plus lane-count and address-width functions.
package ram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    function automatic int lanes_of(input int dw, input int lw);
        return (lw > 0) ? dw / lw : 1;
    endfunction

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ram_1wnr_clr_if.sv
// Bus bundle for ram_1wnr_clr: write port, N read ports and the clear engine.
// master drives requests (we/wlane_en/waddr/din/re/raddr/clr_start); slave
// returns dout/dout_valid/busy/clr_done.
interface ram_1wnr_clr_if
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = 1024,
    parameter int DEPTH      = 256,
    parameter int NUM_RD     = 2,
    parameter int LANE_WIDTH = 64
);
    localparam int LANES = lanes_of(DATA_WIDTH, LANE_WIDTH);
    localparam int AW    = addr_w(DEPTH);

    logic                         we;
    logic [LANES-1:0]             wlane_en;
    logic [AW-1:0]                waddr;
    logic [DATA_WIDTH-1:0]        din;
    logic [NUM_RD-1:0]            re;
    logic [NUM_RD*AW-1:0]         raddr;
    logic [NUM_RD*DATA_WIDTH-1:0] dout;
    logic [NUM_RD-1:0]            dout_valid;
    logic                         clr_start;
    logic                         busy;
    logic                         clr_done;

    modport master (
        output we, wlane_en, waddr, din, re, raddr, clr_start,
        input  dout, dout_valid, busy, clr_done
    );

    modport slave (
        input  we, wlane_en, waddr, din, re, raddr, clr_start,
        output dout, dout_valid, busy, clr_done
    );

endinterface

// File: rtl/ram_1wnr_clr_rd_port.sv
// One read port: captures request, bypass info and range flag alongside the
// array read, merges forwarded lanes, zeroes out-of-range reads, and registers
// the result for 1 or 2 cycles of latency.
// Ports: rd_en/rd_addr request, rd_word raw array word (one cycle later),
// wr_* the same-cycle accepted write, dout/dout_valid result.
module ram_rd_port
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = 1024,
    parameter int DEPTH      = 256,
    parameter int LANE_WIDTH = 64,
    parameter int RD_LATENCY = 1,
    parameter int BYPASS     = 1,
    localparam int LANES     = lanes_of(DATA_WIDTH, LANE_WIDTH),
    localparam int AW        = addr_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_word,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [LANES-1:0]      wr_lane_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid
);

    logic                  v1_q;
    logic                  zero_q;
    logic                  hit_q;
    logic [DATA_WIDTH-1:0] byp_data_q;
    logic [LANES-1:0]      byp_en_q;
    logic [DATA_WIDTH-1:0] merged;

    // zero_q resets high so dout reads 0 before any array word is captured.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            zero_q <= 1'b1;
            hit_q  <= 1'b0;
        end else begin
            v1_q <= rd_en;
            if (rd_en) begin
                zero_q <= 32'(rd_addr) >= DEPTH;
                hit_q  <= (BYPASS != 0) && wr_en
                          && (wr_addr == rd_addr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            byp_data_q <= wr_data;
            byp_en_q   <= wr_lane_en;
        end
    end

    // The array itself is read-first; write-first comes from this overlay.
    always_comb begin
        merged = rd_word;
        for (int i = 0; i < LANES; i++) begin
            if (hit_q && byp_en_q[i]) begin
                merged[i*LANE_WIDTH +: LANE_WIDTH] =
                    byp_data_q[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
        if (zero_q) begin
            merged = '0;
        end
    end

    if (RD_LATENCY == 1) begin : g_lat1
        // Stage-1 registers only move on accepted reads, so dout holds.
        assign dout       = merged;
        assign dout_valid = v1_q;
    end else begin : g_lat2
        logic [DATA_WIDTH-1:0] d2_q;
        logic                  v2_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                d2_q <= '0;
                v2_q <= 1'b0;
            end else begin
                v2_q <= v1_q;
                if (v1_q) begin
                    d2_q <= merged;
                end
            end
        end

        assign dout       = d2_q;
        assign dout_valid = v2_q;
    end

endmodule

// File: rtl/ram_1wnr_clr.sv
// Parametrised 1-write / N-read RAM with lane write enables and a clear engine.
// Ports: clk, rst_n (sync, active-low) and bus (slave side of ram_1wnr_clr_if).
module ram_1wnr_clr
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = 1024,
    parameter int DEPTH      = 256,
    parameter int NUM_RD     = 2,
    parameter int LANE_WIDTH = 64,
    parameter int RD_LATENCY = 1,
    parameter int BYPASS     = 1
) (
    input logic           clk,
    input logic           rst_n,
    ram_1wnr_clr_if.slave bus
);

    localparam int LANES = lanes_of(DATA_WIDTH, LANE_WIDTH);
    localparam int AW    = addr_w(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    if (DATA_WIDTH % LANE_WIDTH != 0) begin : g_bad_lane
        $error("DATA_WIDTH must be a multiple of LANE_WIDTH");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_lat
        $error("RD_LATENCY must be 1 or 2");
    end
    if (NUM_RD < 1 || NUM_RD > 8) begin : g_bad_nrd
        $error("NUM_RD must be in 1..8");
    end

    state_t            state_q;
    state_t            state_d;
    logic [AW-1:0]     clr_addr_q;
    logic [AW-1:0]     clr_addr_d;
    logic              done_q;
    logic              done_d;
    logic              idle;
    logic              clr_we;
    logic              usr_we;
    logic [NUM_RD-1:0] rd_en;

    (* ram_style = "block" *)
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q [NUM_RD];
    logic [DATA_WIDTH-1:0] pdout [NUM_RD];

    assign idle   = (state_q == IDLE);
    assign clr_we = (state_q == CLEAR);
    assign usr_we = idle && bus.we && (32'(bus.waddr) < DEPTH);
    assign rd_en  = idle ? bus.re : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.clr_start) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            CLEAR: begin
                if (clr_addr_q == LAST) begin
                    state_d    = IDLE;
                    clr_addr_d = '0;
                    done_d     = 1'b1;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // No reset on the array so it stays in block RAM; the sweep zeroes it.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr_q] <= '0;
        end else if (usr_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.wlane_en[i]) begin
                    mem[bus.waddr][i*LANE_WIDTH +: LANE_WIDTH] <=
                        bus.din[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
        for (int k = 0; k < NUM_RD; k++) begin
            if (rd_en[k]) begin
                rd_q[k] <= mem[bus.raddr[k*AW +: AW]];
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_port
        ram_rd_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .LANE_WIDTH (LANE_WIDTH),
            .RD_LATENCY (RD_LATENCY),
            .BYPASS     (BYPASS)
        ) u_port (
            .clk        (clk),
            .rst_n      (rst_n),
            .rd_en      (rd_en[k]),
            .rd_addr    (bus.raddr[k*AW +: AW]),
            .rd_word    (rd_q[k]),
            .wr_en      (usr_we),
            .wr_addr    (bus.waddr),
            .wr_data    (bus.din),
            .wr_lane_en (bus.wlane_en),
            .dout       (pdout[k]),
            .dout_valid (bus.dout_valid[k])
        );
        assign bus.dout[k*DATA_WIDTH +: DATA_WIDTH] = pdout[k];
    end

    assign bus.busy     = clr_we;
    assign bus.clr_done = done_q;

endmodule

// File: tb/tb_ram_1wnr_clr.sv
// Scoreboard bench: two instances (latency 2 write-first, latency 1
// read-first) share stimulus and are checked against an array model.
module tb_ram_1wnr_clr;
    import ram_pkg::*;

    localparam int DW    = 64;
    localparam int LW    = 16;
    localparam int DEPTH = 200;
    localparam int NR    = 4;
    localparam int LANES = DW / LW;
    localparam int AW    = 8;

    typedef struct {
        int           due;
        logic [DW-1:0] d;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              we = 1'b0;
    logic [LANES-1:0]  wlane_en = '0;
    logic [AW-1:0]     waddr = '0;
    logic [DW-1:0]     din = '0;
    logic [NR-1:0]     re = '0;
    logic [NR*AW-1:0]  raddr = '0;
    logic              clr_start = 1'b0;

    ram_1wnr_clr_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH),
                      .NUM_RD(NR), .LANE_WIDTH(LW)) ifa ();
    ram_1wnr_clr_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH),
                      .NUM_RD(NR), .LANE_WIDTH(LW)) ifb ();

    assign ifa.we = we;
    assign ifa.wlane_en = wlane_en;
    assign ifa.waddr = waddr;
    assign ifa.din = din;
    assign ifa.re = re;
    assign ifa.raddr = raddr;
    assign ifa.clr_start = clr_start;
    assign ifb.we = we;
    assign ifb.wlane_en = wlane_en;
    assign ifb.waddr = waddr;
    assign ifb.din = din;
    assign ifb.re = re;
    assign ifb.raddr = raddr;
    assign ifb.clr_start = clr_start;

    ram_1wnr_clr #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_RD(NR),
        .LANE_WIDTH(LW), .RD_LATENCY(2), .BYPASS(1)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    ram_1wnr_clr #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_RD(NR),
        .LANE_WIDTH(LW), .RD_LATENCY(1), .BYPASS(0)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   clear_end = 0;
    bit   chk_en = 1'b0;
    bit   exp_busy = 1'b0;
    bit   exp_done = 1'b0;

    logic [DW-1:0] mem_m [DEPTH];
    exp_t          qa [NR][$];
    exp_t          qb [NR][$];
    logic [DW-1:0] last_a [NR];
    logic [DW-1:0] last_b [NR];

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // Word a port should return for address a given this cycle's write.
    function automatic logic [DW-1:0] model_rd(input int a, input bit byp);
        logic [DW-1:0] w;
        if (a >= DEPTH) return '0;
        w = mem_m[a];
        if (byp && we && int'(waddr) == a) begin
            for (int i = 0; i < LANES; i++) begin
                if (wlane_en[i]) w[i*LW +: LW] = din[i*LW +: LW];
            end
        end
        return w;
    endfunction

    task automatic zero_model();
        foreach (mem_m[i]) mem_m[i] = '0;
    endtask

    // Apply the current cycle's inputs to the model, then advance one clock.
    task automatic tick();
        int a;
        if (!rst_n) begin
            clear_end = cyc + 1 + DEPTH;
            zero_model();
        end else if (cyc >= clear_end) begin
            for (int k = 0; k < NR; k++) begin
                if (re[k]) begin
                    a = int'(raddr[k*AW +: AW]);
                    qa[k].push_back('{cyc + 2, model_rd(a, 1'b1)});
                    qb[k].push_back('{cyc + 1, model_rd(a, 1'b0)});
                end
            end
            if (we && int'(waddr) < DEPTH) begin
                for (int i = 0; i < LANES; i++) begin
                    if (wlane_en[i])
                        mem_m[waddr][i*LW +: LW] = din[i*LW +: LW];
                end
            end
            if (clr_start) begin
                clear_end = cyc + 1 + DEPTH;
                zero_model();
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            for (int k = 0; k < NR; k++) begin
                qa[k].delete();
                qb[k].delete();
                last_a[k] = '0;
                last_b[k] = '0;
            end
        end
        cyc++;
        exp_busy = cyc < clear_end;
        exp_done = cyc == clear_end;
        chk_en = 1'b1;
        #1;
    endtask

    task automatic mon_port(input bit b, input int k);
        logic          v;
        logic [DW-1:0] d;
        logic [DW-1:0] last;
        exp_t          e;
        bit            have;
        string         nm;
        nm   = b ? "dutB" : "dutA";
        v    = b ? ifb.dout_valid[k] : ifa.dout_valid[k];
        d    = b ? ifb.dout[k*DW +: DW] : ifa.dout[k*DW +: DW];
        last = b ? last_b[k] : last_a[k];
        have = b ? (qb[k].size() > 0) : (qa[k].size() > 0);
        if (have) e = b ? qb[k][0] : qa[k][0];
        checks++;
        if (v) begin
            if (!have || e.due != cyc) begin
                failures++;
                $display("FAIL %s_p%0d_unexpected_valid cyc=%0d got=%h",
                         nm, k, cyc, d);
            end else begin
                if (d !== e.d) begin
                    failures++;
                    $display("FAIL %s_p%0d_data cyc=%0d got=%h want=%h",
                             nm, k, cyc, d, e.d);
                end
                if (b) void'(qb[k].pop_front());
                else   void'(qa[k].pop_front());
            end
            if (b) last_b[k] = d;
            else   last_a[k] = d;
        end else if (have && e.due <= cyc) begin
            failures++;
            $display("FAIL %s_p%0d_missing_valid cyc=%0d want=%h",
                     nm, k, cyc, e.d);
            if (b) void'(qb[k].pop_front());
            else   void'(qa[k].pop_front());
        end else if (d !== last) begin
            failures++;
            $display("FAIL %s_p%0d_hold cyc=%0d got=%h want=%h",
                     nm, k, cyc, d, last);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busyA", DW'(ifa.busy), DW'(exp_busy));
            chk("busyB", DW'(ifb.busy), DW'(exp_busy));
            chk("doneA", DW'(ifa.clr_done), DW'(exp_done));
            chk("doneB", DW'(ifb.clr_done), DW'(exp_done));
            for (int k = 0; k < NR; k++) begin
                mon_port(1'b0, k);
                mon_port(1'b1, k);
            end
        end
    end

    task automatic idle_in();
        we = 1'b0;
        wlane_en = '0;
        re = '0;
        clr_start = 1'b0;
    endtask

    task automatic set_rd(input int k, input int a);
        re[k] = 1'b1;
        raddr[k*AW +: AW] = AW'(a);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 7) == 0)
            return AW'($urandom_range(DEPTH, 255));
        return AW'($urandom_range(0, 31));
    endfunction

    task automatic rand_traffic(input int clr_odds);
        we = 1'($urandom_range(0, 1));
        wlane_en = LANES'($urandom);
        waddr = rand_addr();
        din = {$urandom, $urandom};
        re = NR'($urandom);
        for (int k = 0; k < NR; k++) raddr[k*AW +: AW] = rand_addr();
        clr_start = (clr_odds > 0) && ($urandom_range(0, clr_odds - 1) == 0);
    endtask

    // Busy phase: push writes, reads and clr_start every cycle.
    task automatic hammer_until_idle();
        int guard;
        guard = 0;
        while (cyc < clear_end && guard < 2 * DEPTH + 10) begin
            rand_traffic(2);
            we = 1'b1;
            re = '1;
            tick();
            guard++;
        end
        idle_in();
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        hammer_until_idle();

        for (int k = 0; k < NR; k++) set_rd(k, 17);
        tick();
        idle_in();

        we = 1'b1; wlane_en = '1; waddr = 8'd3; din = {4{16'hA5A5}};
        tick();
        wlane_en = 4'b0001; din = '1;
        tick();
        idle_in();
        set_rd(0, 3);
        tick();
        idle_in();

        set_rd(0, 0); set_rd(1, 3); set_rd(2, 3); set_rd(3, DEPTH - 1);
        tick();
        idle_in();

        we = 1'b1; wlane_en = '1; waddr = 8'd250; din = {$urandom, $urandom};
        set_rd(0, 250); set_rd(1, 3); set_rd(2, 250); set_rd(3, 0);
        tick();
        idle_in();

        we = 1'b1; wlane_en = 4'b0101; waddr = 8'd9;
        din = {$urandom, $urandom};
        for (int k = 0; k < NR; k++) set_rd(k, 9);
        tick();
        idle_in();
        for (int k = 0; k < NR; k++) set_rd(k, 9);
        tick();
        idle_in();

        repeat (600) begin
            if (cyc < clear_end) hammer_until_idle();
            rand_traffic(300);
            tick();
        end
        idle_in();
        hammer_until_idle();

        for (int a = 0; a < DEPTH; a++) begin
            we = 1'b1; wlane_en = '1; waddr = AW'(a);
            din = {$urandom, $urandom};
            tick();
        end
        idle_in();
        clr_start = 1'b1;
        tick();
        hammer_until_idle();
        for (int a = 0; a < DEPTH; a += NR) begin
            for (int k = 0; k < NR; k++) set_rd(k, a + k);
            tick();
        end
        idle_in();

        for (int k = 0; k < NR; k++) set_rd(k, k + 3);
        tick();
        rst_n = 1'b0;
        tick();
        idle_in();
        tick();
        rst_n = 1'b1;
        repeat (100) begin
            rand_traffic(2);
            tick();
        end
        rst_n = 1'b0;
        idle_in();
        tick();
        rst_n = 1'b1;
        hammer_until_idle();

        repeat (20) begin
            re = NR'($urandom);
            for (int k = 0; k < NR; k++) raddr[k*AW +: AW] = rand_addr();
            tick();
        end
        idle_in();
        repeat (4) tick();

        for (int k = 0; k < NR; k++) begin
            chk("drainA", DW'(qa[k].size()), '0);
            chk("drainB", DW'(qb[k].size()), '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_1wnr_clr.md
# ram_1wnr_clr

Parametrised one-write / N-read memory for the matrix-multiply datapath, generalising the team's dual-read BRAM. It adds a configurable read-port count, per-lane write enables, a selectable read latency, optional write-first bypass, per-port read-valid tracking, and a sequenced clear engine. The clear engine replaces the per-entry reset loop so the array still maps to block RAM. It sits between the MAC array result writers and the operand fetchers that read partial-sum rows.

## Interface
- DATA_WIDTH, 1024, word width in bits
- DEPTH, 256, number of words; need not be a power of two
- NUM_RD, 2, number of independent read ports (1..8)
- LANE_WIDTH, 64, write-enable granularity; DATA_WIDTH must be a multiple of it
- RD_LATENCY, 1, read latency in cycles, 1 or 2
- BYPASS, 1, 1 = write-first forwarding on address match; 0 = read-first
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- we  in  1  write request
- wlane_en  in  LANES  per-lane write enable; LANES = DATA_WIDTH/LANE_WIDTH
- waddr  in  AW  write address; AW = $clog2(DEPTH)
- din  in  DATA_WIDTH  write data
- re  in  NUM_RD  per-port read request
- raddr  in  NUM_RD*AW  read addresses; port k occupies bits [k*AW +: AW]
- dout  out  NUM_RD*DATA_WIDTH  read data; port k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- dout_valid  out  NUM_RD  per-port data-valid
- clr_start  in  1  request a full-array clear
- busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse when a clear completes

## Operation
- FSM states are IDLE and CLEAR. Reset forces CLEAR with clr_addr=0.
- In CLEAR, zero is written to clr_addr each cycle and clr_addr increments.
- After the write to DEPTH-1, the FSM goes to IDLE and pulses clr_done.
- A clr_start pulse in IDLE enters CLEAR with clr_addr=0. clr_start is ignored while in CLEAR.
- While busy=1, user writes are dropped and read requests are dropped: dout_valid stays 0 and dout holds its value.
- Write: in IDLE, with we=1 and waddr<DEPTH, each lane i where wlane_en[i]=1 takes din lane i. Other lanes keep their contents.
- Writes with waddr>=DEPTH are ignored.
- Read: in IDLE, re[k]=1 samples raddr_k. The word appears on dout_k after RD_LATENCY cycles, with dout_valid[k]=1 in that same cycle.
- Reads with raddr_k>=DEPTH return all-zero data and dout_valid[k]=1.
- With re[k]=0, dout_k holds its last value and dout_valid[k]=0.
- With BYPASS=1, a same-cycle we with waddr==raddr_k returns the merged word: new data on enabled lanes, old data on all other lanes.
- With BYPASS=0, the same case returns the pre-write word.
- All ports may read the same address in the same cycle, with no conflict.
- An elaboration error is raised if DATA_WIDTH%LANE_WIDTH!=0, RD_LATENCY is not 1 or 2, or NUM_RD is outside 1..8.

## Timing
- While rst_n=0: dout=0, dout_valid=0, busy=1, clr_done=0, FSM in CLEAR, clr_addr=0.
- Clear sequence, counting from the first cycle with rst_n=1 (cycle 0), or from the cycle after clr_start is sampled:
  - Cycle 0 writes address 0.
  - Cycle DEPTH-1 writes address DEPTH-1.
  - Cycle DEPTH: busy=0 and clr_done=1 for exactly one cycle. This is the first cycle user traffic is accepted.
- Reset asserted mid-clear restarts the sweep at address 0.
- Reset asserted mid-read clears all in-flight valids; nothing emerges after reset.
- Read pipeline: a request at cycle t gives data and valid at t+RD_LATENCY.
- Read pipeline throughput: one request per port per cycle, with no stall input.
- A write at cycle t is visible to reads issued at cycle t+1 or later, and at cycle t itself when BYPASS=1.

## Structure
- Package ram_pkg holds the state typedef (IDLE, CLEAR) and functions for lane count and address width.
- One sub-module, ram_rd_port, implements a single port: address/valid capture, bypass lane merge, out-of-range zeroing, and the 1- or 2-stage output register. It is instantiated NUM_RD times.
- The top level holds the memory array with ram_style "block", the write-lane merge, the clear FSM, and clr_addr.

## Test plan
- Reset then idle, DEPTH=256 -> busy=1 for 256 cycles, clr_done pulses on cycle 256; a read of address 17 returns 0 with valid.
- Write 0xA5 pattern to address 3 with wlane_en=all-ones, then wlane_en=0x0001 with din=0xFF.. -> read of address 3 returns lane0=0xFF.., all other lanes 0xA5...
- NUM_RD=4, RD_LATENCY=2, all ports reading addresses 0,3,3,255 in one cycle -> four correct words with all valids high exactly 2 cycles later.
- Same-cycle write and read to address 9 -> new data when BYPASS=1, old data when BYPASS=0; the next-cycle read returns new data in both cases.
- clr_start after filling memory, with we and re asserted every cycle during busy -> no writes land, no valids, all addresses 0 after clr_done.
- DEPTH=200, write and read at address 250 -> memory unchanged, dout=0 with valid; rst_n pulsed at clear cycle 100 -> sweep restarts and clr_done arrives 200 cycles after release.
